// File: rtl/paralelo_serial_tx_if.sv
// ----------------------------------------------------------------------------
// paralelo_serial_tx_if
// Bundles the link-layer handshake and the serial lane outputs of the
// transmit-side parallel-to-serial converter.
//   data_in   [7:0] parallel symbol offered by the link layer
//   valid_in        data_in holds a symbol to send
//   ready_out       converter samples data_in on the next rising edge
//   data_out        serial bitstream, MSB first
//   sym_start       data_out currently carries bit 7 of a symbol
//   idle_tx         symbol currently shifted out is an inserted COM
// master: link-layer side, slave: converter side.
// ----------------------------------------------------------------------------
interface paralelo_serial_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       sym_start;
  logic       idle_tx;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  sym_start,
    input  idle_tx
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output sym_start,
    output idle_tx
  );
endinterface

// File: rtl/paralelo_serial_tx.sv
// ----------------------------------------------------------------------------
// paralelo_serial_tx
// Transmit-side parallel-to-serial converter of the PCI phy lane. Shifts 8-bit
// symbols out MSB-first, one bit per clk_1 rising edge. After reset it sends
// INIT_COMS COM symbols, then accepts link-layer data; when nothing is
// offered it inserts COM_SYMBOL so the receiver can keep alignment.
// Ports:
//   clk_1  bit clock
//   reset  asynchronous, active-low reset
//   bus    paralelo_serial_tx_if.slave (data_in, valid_in, ready_out,
//          data_out, sym_start, idle_tx)
// ----------------------------------------------------------------------------
module paralelo_serial_tx #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned INIT_COMS  = 4
) (
  input  logic                    clk_1,
  input  logic                    reset,
  paralelo_serial_tx_if.slave     bus
);

  localparam logic [3:0] INIT_COMS_C = 4'(INIT_COMS);

  typedef enum logic {
    ST_INIT   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t     state_r,     state_nxt_s;
  logic [7:0] shift_r,     shift_nxt_s;
  logic [2:0] bit_cnt_r,   bit_cnt_nxt_s;
  logic [3:0] com_cnt_r,   com_cnt_nxt_s;
  logic       sym_start_r, sym_start_nxt_s;
  logic       idle_tx_r,   idle_tx_nxt_s;
  logic       load_s;

  // A symbol boundary: the last bit of the current symbol is on the wire.
  assign load_s        = (bit_cnt_r == 3'd7);

  assign bus.data_out  = shift_r[7];
  assign bus.sym_start = sym_start_r;
  assign bus.idle_tx   = idle_tx_r;
  // Decoded from registers only so the link layer never sees an input loop.
  assign bus.ready_out = (state_r == ST_ACTIVE) && (bit_cnt_r == 3'd7);

  // Next-state and datapath decode: load a new symbol or keep shifting.
  always_comb begin
    state_nxt_s     = state_r;
    shift_nxt_s     = shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    com_cnt_nxt_s   = com_cnt_r;
    sym_start_nxt_s = 1'b0;
    idle_tx_nxt_s   = idle_tx_r;

    if (load_s) begin
      bit_cnt_nxt_s   = 3'd0;
      sym_start_nxt_s = 1'b1;
      case (state_r)
        ST_INIT: begin
          // Preamble: valid_in is ignored until all COMs are out.
          shift_nxt_s   = COM_SYMBOL;
          idle_tx_nxt_s = 1'b1;
          com_cnt_nxt_s = com_cnt_r + 4'd1;
          if ((com_cnt_r + 4'd1) == INIT_COMS_C) begin
            state_nxt_s = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_INIT;
          end
        end
        ST_ACTIVE: begin
          // ready_out is high here, so valid_in marks the handshake.
          if (bus.valid_in) begin
            shift_nxt_s   = bus.data_in;
            idle_tx_nxt_s = 1'b0;
          end else begin
            shift_nxt_s   = COM_SYMBOL;
            idle_tx_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s   = ST_INIT;
          shift_nxt_s   = COM_SYMBOL;
          idle_tx_nxt_s = 1'b1;
        end
      endcase
    end else begin
      shift_nxt_s   = {shift_r[6:0], 1'b0};
      bit_cnt_nxt_s = bit_cnt_r + 3'd1;
    end
  end

  // State and datapath registers; bit_cnt resets to 7 so E1 is a load edge.
  always_ff @(posedge clk_1 or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_INIT;
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd7;
      com_cnt_r   <= 4'd0;
      sym_start_r <= 1'b0;
      idle_tx_r   <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      com_cnt_r   <= com_cnt_nxt_s;
      sym_start_r <= sym_start_nxt_s;
      idle_tx_r   <= idle_tx_nxt_s;
    end
  end

endmodule

// File: doc/paralelo_serial_tx.md
# paralelo_serial_tx

Transmit-side parallel-to-serial converter of the PCI phy lane. It takes 8-bit symbols from the link layer and shifts them out MSB-first on a single bit clock. When no data is offered it inserts the COM/IDLE symbol (0xBC), which the lane's serial-to-parallel receiver uses for alignment and idle detection. After reset it sends a fixed preamble of COM symbols before it accepts any data.

## Interface
Parameters:
- `COM_SYMBOL`, default 8'hBC: idle/alignment symbol inserted when no data is offered.
- `INIT_COMS`, default 4: number of COM symbols sent after reset before data is accepted. Legal range 1..15.

Ports:
- `clk_1`  input  1  bit clock. One serial bit per rising edge.
- `reset`  input  1  asynchronous, active-low reset. 0 forces reset; 1 is normal operation.
- `data_in`  input  8  parallel symbol from the link layer.
- `valid_in`  input  1  `data_in` holds a symbol to send.
- `ready_out`  output  1  the block will sample `data_in` on the next rising edge.
- `data_out`  output  1  serial bitstream, MSB first.
- `sym_start`  output  1  high in the cycle where `data_out` carries bit 7 of a symbol.
- `idle_tx`  output  1  the symbol currently being shifted out was an inserted COM.

## Operation
- State register, asynchronously cleared when `reset`=0: `shift_reg[7:0]`=0, `bit_cnt[2:0]`=7, `com_cnt[3:0]`=0, state=INIT.
- Reset values of the outputs: `data_out`=0, `sym_start`=0, `idle_tx`=1, `ready_out`=0.
- `data_out` = `shift_reg[7]`. `ready_out` = (state==ACTIVE) && (`bit_cnt`==7). `ready_out` is decoded combinationally from registers only, never from inputs.
- Load edge: any rising edge with `bit_cnt`==7. On a load edge:
  - `bit_cnt` returns to 0.
  - `shift_reg` is loaded with the next symbol.
  - `sym_start` is registered to 1.
  - `idle_tx` is registered to 1 if the loaded symbol is an inserted COM, 0 otherwise.
- Any other edge: `shift_reg` <= {`shift_reg[6:0]`, 0}, `bit_cnt`++, `sym_start` <= 0, `idle_tx` holds.
- State INIT:
  - Every load edge loads `COM_SYMBOL` and increments `com_cnt`. `valid_in` is ignored and `ready_out` stays 0.
  - On the load edge that loads the `INIT_COMS`-th COM, the state moves to ACTIVE.
- State ACTIVE:
  - On a load edge with `valid_in`=1, `data_in` is loaded. This edge is the handshake (`ready_out` && `valid_in`), and `idle_tx` goes to 0.
  - On a load edge with `valid_in`=0, `COM_SYMBOL` is loaded and `idle_tx` goes to 1.
  - ACTIVE is left only through reset.
- `data_in` is sampled only on a handshake edge. Changes to `data_in` at other times have no effect.
- If `data_in` equals `COM_SYMBOL`, it is sent unchanged with `idle_tx`=0. The link layer must not send this value as payload. The transmitter does not escape it.

## Timing
- Edge E1 (first rising edge after `reset` rises) is a load edge and loads COM #1.
  - In cycle E1..E2, `data_out`=1 (bit 7 of 0xBC) and `sym_start`=1.
- COMs load on E1, E9, E17, … The `INIT_COMS`-th COM loads on edge E(8·`INIT_COMS`−7), and the state moves to ACTIVE on that edge.
- With the default of 4:
  - ACTIVE is entered on E25.
  - `ready_out` is first high in cycle E32..E33.
  - The first data byte loads on E33, and its MSB appears on `data_out` right after E33.
- In ACTIVE:
  - `ready_out` is high for exactly 1 of every 8 cycles.
  - Handshake to first serial bit latency is 0 cycles after the edge.
  - The last bit (bit 0) of a symbol leaves `data_out` at the following load edge.
- Throughput is one symbol per 8 clocks. No bubbles between consecutive symbols.
- Reset asserted mid-symbol: all outputs take their reset values immediately, with no clock needed. The partial symbol is discarded. After release, INIT restarts with the full `INIT_COMS` preamble.
- `valid_in` high while `ready_out`=0 has no effect. The link layer holds `valid_in`/`data_in` until it sees a handshake.

## Test plan
- Reset release with `valid_in`=0 throughout, default parameters:
  - `data_out` repeats the pattern 1,0,1,1,1,1,0,0 forever.
  - `sym_start` is high every 8th cycle, starting at E1.
  - `idle_tx`=1 throughout.
  - `ready_out` is first high in cycle E32..E33.
- `valid_in`=1 with `data_in`=8'hA5 held from reset:
  - E1..E32 carry four COMs.
  - From E33, bits 1,0,1,0,0,1,0,1 appear, with `idle_tx`=0.
- Back-to-back handshakes 8'h00, 8'hFF, 8'h3C:
  - 24 contiguous bits 00000000 11111111 00111100.
  - `sym_start` is high at E33, E41 and E49, with no COM between the symbols.
- `valid_in` dropped for one slot between 8'h12 and 8'h34:
  - Output is 8'h12, then 8'hBC with `idle_tx`=1, then 8'h34 with `idle_tx`=0.
- `reset` pulsed low for 3 cycles while bit 4 of 8'hA5 is being sent:
  - `data_out`, `sym_start` and `ready_out` go to 0 and `idle_tx` goes to 1 asynchronously.
  - After release, four COMs are sent again before `ready_out` rises.
- `INIT_COMS`=1:
  - ACTIVE is entered on E1.
  - `ready_out` is high in cycle E8..E9.
  - The first data byte loads on E9.
